// File: rtl/iob_img_loader_pkg.sv
// Shared definitions for the image loader: FSM state encoding and word/strobe constants.
package iob_img_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [BYTES_PER_WORD-1:0] STRB_FULL = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CKSUM   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;
endpackage

// File: rtl/iob_img_loader_byte_packer.sv
// Byte-to-word packer: places successive bytes little-endian into a DATA_W word and
// flags the cycle in which the last byte of a word is accepted.
module iob_img_loader_byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_vld_o
);
  localparam int BPW = DATA_W / 8;
  localparam int CW  = $clog2(BPW);

  logic [CW-1:0]        cnt_q;
  logic [BPW-1:0][7:0]  word_q, word_d;

  // Merge the incoming byte combinationally so the full word is usable on the last byte.
  always_comb begin
    word_d = word_q;
    if (byte_vld_i) word_d[cnt_q] = byte_i;
  end

  assign word_o     = word_d;
  assign word_vld_o = byte_vld_i && (cnt_q == CW'(BPW - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_vld_i) begin
      cnt_q  <= cnt_q + 1'b1;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/iob_img_loader.sv
// Image loader: packs a byte stream little-endian into words and writes each to memory.
// Define IMG_LOADER_CHECKSUM_EN to check a 4-byte trailing sum of all written words.
module iob_img_loader
  import iob_img_loader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                s_valid_i,
  input  logic [7:0]          s_data_i,
  output logic                s_ready_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  state_e                state_q;
  logic [ADDR_W-1:0]     base_q, m_addr_q;
  logic [LEN_W-1:0]      len_q, word_idx_q;
  logic [DATA_W-1:0]     m_wdata_q, pk_word;
  logic [DATA_W/8-1:0]   m_wstrb_q;
  logic                  s_ready_q, m_valid_q, busy_q, done_q;
  logic                  pk_clear, pk_vld, pk_word_vld, last_word;

  assign pk_clear  = (state_q == ST_IDLE) && start_i;
  assign pk_vld    = s_valid_i && s_ready_q;
  assign last_word = (word_idx_q == len_q - LEN_W'(1));

  // One packer serves both the image words and the checksum trailer.
  iob_img_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (pk_clear),
    .byte_vld_i (pk_vld),
    .byte_i     (s_data_i),
    .word_o     (pk_word),
    .word_vld_o (pk_word_vld)
  );

`ifdef IMG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IMG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          base_q     <= base_i & ~ADDR_W'(3);
          len_q      <= len_i;
          word_idx_q <= '0;
          busy_q     <= 1'b1;
`ifdef IMG_LOADER_CHECKSUM_EN
          sum_q      <= '0;
          err_q      <= 1'b0;
`endif
          if (len_i == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= ST_COLLECT;
            s_ready_q <= 1'b1;
          end
        end
        ST_COLLECT: if (pk_word_vld) begin
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b1;
          m_addr_q  <= base_q + ADDR_W'({word_idx_q, 2'b00});
          m_wdata_q <= pk_word;
          m_wstrb_q <= STRB_FULL;
`ifdef IMG_LOADER_CHECKSUM_EN
          sum_q     <= sum_q + pk_word;
`endif
          state_q   <= ST_WRITE;
        end
        ST_WRITE: if (m_ready_i) begin
          m_valid_q  <= 1'b0;
          m_wstrb_q  <= '0;
          word_idx_q <= word_idx_q + 1'b1;
          if (last_word) begin
`ifdef IMG_LOADER_CHECKSUM_EN
            state_q   <= ST_CKSUM;
            s_ready_q <= 1'b1;
`else
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
`endif
          end else begin
            state_q   <= ST_COLLECT;
            s_ready_q <= 1'b1;
          end
        end
`ifdef IMG_LOADER_CHECKSUM_EN
        ST_CKSUM: if (pk_word_vld) begin
          s_ready_q <= 1'b0;
          err_q     <= (pk_word != sum_q);
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end
`endif
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign m_wstrb_o = m_wstrb_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
endmodule

// File: tb/tb_iob_img_loader.sv
// Bench for iob_img_loader: randomized byte stream and memory latency against a
// queue-based model of the expected word writes, done pulses and checksum result.
module tb_iob_img_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] len = '0;
  logic        s_valid = 1'b0, s_ready;
  logic [7:0]  s_data = '0;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        busy, done, err;

  always #5 clk = ~clk;

  iob_img_loader #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_i(base), .len_i(len),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .m_valid_o(m_valid), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_ready_i(m_ready), .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wq[$];
  logic [7:0]  src_q[$];
  logic [7:0]  pat[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          done_seen = 0, writes_seen = 0;
  int          rdy_lo = 0, rdy_hi = 2;
  logic        exp_err = 1'b0;
  logic [31:0] last_sum = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", nm, why);
  endtask

  function automatic logic [31:0] le_word(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic pulse_start(input logic [31:0] b, input int n);
    @(posedge clk); #1;
    start = 1'b1; base = b; len = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; base = $urandom; len = 16'($urandom);
  endtask

  // Model: word k goes to (base & ~3) + 4k, bytes little-endian; trailer = sum or zeros.
  task automatic prep_load(input logic [31:0] b, input int n, input int bad);
    logic [31:0] sum, w, ab, tr;
    logic [7:0]  by[4];
    sum = '0;
    ab  = b & 32'hFFFF_FFFC;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (pat.size() > 0) by[j] = pat.pop_front();
        else by[j] = 8'($urandom);
        src_q.push_back(by[j]);
      end
      w = le_word(by[0], by[1], by[2], by[3]);
      sum += w;
      exp_wq.push_back('{a: ab + 32'(4 * k), d: w});
    end
    tr = (bad != 0) ? 32'h0 : sum;
    exp_err = 1'b0;
`ifdef IMG_LOADER_CHECKSUM_EN
    if (n > 0) begin
      for (int j = 0; j < 4; j++) src_q.push_back(tr[8*j +: 8]);
      exp_err = (tr != sum);
    end
`endif
    last_sum = sum;
    pulse_start(b, n);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_seen == d0 && t < 4000) begin @(negedge clk); t++; end
    if (done_seen == d0) fail_now("done_timeout", "no done pulse within 4000 cycles");
    @(negedge clk);
    chk("writes_left", exp_wq.size(), 0);
    chk("bytes_left", src_q.size(), 0);
  endtask

  task automatic run_load(input logic [31:0] b, input int n, input int bad);
    int d0, w0;
    d0 = done_seen; w0 = writes_seen;
    prep_load(b, n, bad);
    wait_done(d0);
    chk("write_count", writes_seen - w0, n);
  endtask

  // Byte stream source with random gaps; data held until accepted.
  initial begin : stream_drv
    bit will = 1'b0;
    logic [7:0] tmp;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        s_valid = 1'b0; will = 1'b0;
      end else begin
        if (will && src_q.size() > 0) tmp = src_q.pop_front();
        if (src_q.size() > 0 && (s_valid || $urandom_range(0, 3) != 0)) begin
          s_valid = 1'b1; s_data = src_q[0];
        end else s_valid = 1'b0;
        will = s_valid && s_ready;
      end
    end
  end

  // Memory responder: single-cycle m_ready after a random latency.
  initial begin : mem_resp
    int cnt = 0, dly = 0;
    bit armed = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_ready = 1'b0; armed = 1'b0;
      end else if (m_ready) m_ready = 1'b0;
      else if (m_valid) begin
        if (!armed) begin dly = $urandom_range(rdy_lo, rdy_hi); cnt = 0; armed = 1'b1; end
        if (cnt >= dly) begin m_ready = 1'b1; armed = 1'b0; end
        else cnt++;
      end
    end
  end

  // Compare process: every cycle, outputs against the model queues.
  initial begin : monitor
    bit  prev_done = 1'b0;
    wr_t tmp;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_done = 1'b0;
      else begin
        if (prev_done) begin
          chk("done_one_cycle", done, 0);
          chk("busy_after_done", busy, 0);
        end
        if (m_valid) begin
          chk("s_ready_in_write", s_ready, 0);
          chk("busy_in_write", busy, 1);
          if (exp_wq.size() == 0) fail_now("unexpected_write", $sformatf("addr 0x%08h, none expected", m_addr));
          else begin
            chk("m_addr", m_addr, exp_wq[0].a);
            chk("m_wdata", m_wdata, exp_wq[0].d);
            chk("m_wstrb", m_wstrb, 32'hF);
            if (m_ready) begin tmp = exp_wq.pop_front(); writes_seen++; end
          end
        end
        if (s_ready) chk("busy_in_collect", busy, 1);
        if (done) begin
          done_seen++;
          chk("busy_at_done", busy, 1);
          chk("err_at_done", err, exp_err);
        end
        prev_done = done;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, w0, t;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);  chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);  chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);        chk("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed two-word load, bytes 01..08, ready one cycle after valid.
    rdy_lo = 1; rdy_hi = 1;
    for (int i = 1; i <= 8; i++) pat.push_back(8'(i));
    d0 = done_seen; w0 = writes_seen;
    prep_load(32'h100, 2, 0);
    chk("model_w0_addr", exp_wq[0].a, 32'h100);
    chk("model_w0_data", exp_wq[0].d, 32'h0403_0201);
    chk("model_w1_addr", exp_wq[1].a, 32'h104);
    chk("model_w1_data", exp_wq[1].d, 32'h0807_0605);
    wait_done(d0);
    chk("t1_writes", writes_seen - w0, 2);

    // Zero-length load: done the cycle after start, no bus or stream activity.
    d0 = done_seen; w0 = writes_seen;
    prep_load(32'h200, 0, 0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_m_valid", m_valid, 0);
    chk("len0_s_ready", s_ready, 0);
    repeat (4) @(negedge clk);
    chk("len0_dones", done_seen - d0, 1);
    chk("len0_writes", writes_seen - w0, 0);

    // Slow memory: stream must stall with pending bytes.
    rdy_lo = 5; rdy_hi = 5;
    run_load(32'h8000_0000, 3, 0);

    // Reset while a write is outstanding.
    prep_load(32'h2000, 4, 0);
    t = 0;
    while (!m_valid && t < 200) begin @(negedge clk); t++; end
    if (!m_valid) fail_now("rst_wait", "m_valid never rose");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_s_ready", s_ready, 0);
    src_q.delete();
    exp_wq.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    rdy_lo = 0; rdy_hi = 2;
    d0 = done_seen;
    prep_load(32'h3003, 2, 0);
    chk("model_low_bits", exp_wq[0].a, 32'h3000);
    wait_done(d0);

    // Start pulse during a load is ignored.
    d0 = done_seen; w0 = writes_seen;
    prep_load(32'h400, 3, 0);
    t = 0;
    while (writes_seen == w0 && t < 500) begin @(negedge clk); t++; end
    pulse_start(32'hF000, 7);
    wait_done(d0);
    repeat (10) @(negedge clk);
    chk("ign_start_writes", writes_seen - w0, 3);
    chk("ign_start_dones", done_seen - d0, 1);
    chk("ign_start_busy", busy, 0);

    // Address wrap past the top of memory.
    d0 = done_seen;
    prep_load(32'hFFFF_FFF8, 4, 0);
    chk("model_wrap", exp_wq[2].a, 32'h0);
    wait_done(d0);

`ifdef IMG_LOADER_CHECKSUM_EN
    // Checksum trailer: matching sum then zeros.
    pat.push_back(8'h44); pat.push_back(8'h33); pat.push_back(8'h22); pat.push_back(8'h11);
    d0 = done_seen;
    prep_load(32'h500, 1, 0);
    chk("model_sum", last_sum, 32'h1122_3344);
    wait_done(d0);
    chk("ck_good_err", err, 0);
    pat.push_back(8'h44); pat.push_back(8'h33); pat.push_back(8'h22); pat.push_back(8'h11);
    run_load(32'h500, 1, 1);
    chk("ck_bad_sticky", err, 1);
    pulse_start(32'h600, 2);
    @(negedge clk);
    chk("ck_err_cleared", err, 0);
    src_q.delete();
    for (int k = 0; k < 2; k++) src_q.push_back(8'h00);
    begin
      logic [7:0] z[$];
      z = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
            8'h03, 8'h00, 8'h00, 8'h00};
      src_q.delete();
      foreach (z[i]) src_q.push_back(z[i]);
      exp_wq.push_back('{a: 32'h600, d: 32'h1});
      exp_wq.push_back('{a: 32'h604, d: 32'h2});
      exp_err = 1'b0;
    end
    d0 = done_seen;
    wait_done(d0 - 1 == done_seen ? d0 : d0);
`endif

    // Randomized loads.
    for (int it = 0; it < 12; it++) begin
      rdy_lo = 0; rdy_hi = $urandom_range(0, 4);
      run_load($urandom, $urandom_range(1, 6), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
